adc_moving_avg: RTL
===================

Name: adc_moving_avg

Overview:
Boxcar moving-average filter that sits directly downstream of the SA ADC and upstream of the DAC shift-out stage. Consumes the 14-bit ADC conversion result and its ready strobe, keeps the last 2^LOG2_DEPTH samples in a circular buffer, and emits the floor-mean of that window with its own ready strobe. The output pair drops straight into the shift-out stage's data/ready inputs.

Parameters:
DATA_W, 14, sample and output width in bits
LOG2_DEPTH, 3, log2 of window length; window = 8 samples by default; legal range 1..6

Ports:
clk_i  in  1  system clock (PLL output)
reset_i  in  1  synchronous reset, active-high
data_i  in  DATA_W  ADC sample, unsigned
data_rdy_i  in  1  sample strobe from ADC; rising edge marks a new sample
clear_i  in  1  synchronous flush of the window, active-high
data_o  out  DATA_W  windowed mean, unsigned, floor
data_rdy_o  out  1  one-cycle pulse: data_o updated
valid_o  out  1  high once the window holds DEPTH real samples since last reset/clear

Behaviour:
- Single clock domain, clk_i. Reset is synchronous and active-high on reset_i; all state updates on the rising clk_i edge.
- Reset (reset_i=1): data_o=0, data_rdy_o=0, valid_o=0, sum=0, wr_ptr=0, fill count=0, rdy_prev=0. Buffer contents are not reset; the fill count masks stale entries.
- Sample accept: accept = data_rdy_i & ~rdy_prev; rdy_prev <= data_rdy_i every cycle. If data_rdy_i is held high for N cycles, exactly one sample is taken. If data_rdy_i is high on the first cycle after reset, that counts as a rising edge.
- Oldest value: old = (fill == DEPTH) ? buf[wr_ptr] : 0.
- On accept:
  - sum <= sum + data_i - old
  - buf[wr_ptr] <= data_i
  - wr_ptr <= wr_ptr + 1, wrapping modulo DEPTH
  - fill <= min(fill + 1, DEPTH)
- Sum width is DATA_W + LOG2_DEPTH bits; it can never overflow or underflow.
- Output stage (registered). In the cycle after accept:
  - data_o = new_sum >> LOG2_DEPTH (truncate, no rounding)
  - data_rdy_o = 1 for exactly one cycle
  - Latency is 1 clk from the accepting edge. data_o holds its value between pulses.
- Warm-up: while fill < DEPTH, missing slots count as 0, so output is biased low. valid_o rises in the same cycle as the data_rdy_o that follows the DEPTH-th accept, then stays high.
- clear_i: same effect as reset on sum, wr_ptr, fill, valid_o, rdy_prev, data_rdy_o. data_o holds its last value.
- clear_i and accept in the same cycle: clear wins and the sample is discarded. rdy_prev is still loaded with data_i's strobe, so the held strobe does not retrigger.
- reset_i has priority over clear_i and over accept. Reset asserted mid-window discards all history; no partial pulse appears after reset.
- Back-to-back accepts (strobe toggling every 2 cycles) are supported at full rate; no stall or backpressure exists.
- Behaviour when reset_i is asserted with no clock edge is undefined (synchronous reset only).

Test Plan:
- Reset then 8 single-cycle strobes with data_i=0x3FFF → data_o = 0x07FF, 0x0FFF, …, 0x3FFF (k·0x3FFF>>3 for k=1..8). Each data_rdy_o arrives 1 cycle after its strobe. valid_o rises with the 8th pulse. Internal sum reaches 0x1FFF8.
- Fill window with 8×100, then feed 8×200 → outputs step 112, 125, 137, 150, 162, 175, 187, 200 (floor). valid_o stays 1. Checks circular-buffer wrap of wr_ptr.
- data_rdy_i held high for 5 cycles with data_i=800 → exactly one accept. One data_rdy_o pulse with data_o=100.
- After a full window of 1000s, assert clear_i together with a strobe carrying 4000 → no data_rdy_o, valid_o=0, data_o stays 1000. The next single strobe of 4000 gives data_o=500.
- Assert reset_i for 1 cycle after 5 samples of 0x2000 → all outputs 0 and no pulse. 8 further samples of 0x0008 give final data_o=0x0008 with valid_o=1.
- Minimum-spacing stress: 64 strobes every 2 cycles with pseudo-random data → every data_o equals the reference model's floor(sum of last 8 or available)/8. Exactly 64 data_rdy_o pulses.

Source files
------------

// File: rtl/adc_moving_avg.sv
// Boxcar moving-average filter: keeps the last 2^LOG2_DEPTH ADC samples and
// emits the floor-mean of the window one clock after each accepted sample.
module adc_moving_avg #(
  parameter int unsigned DATA_W     = 14,
  parameter int unsigned LOG2_DEPTH = 3
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              data_rdy_i,
  input  logic              clear_i,
  output logic [DATA_W-1:0] data_o,
  output logic              data_rdy_o,
  output logic              valid_o
);

  localparam int unsigned DEPTH  = 1 << LOG2_DEPTH;
  localparam int unsigned SUM_W  = DATA_W + LOG2_DEPTH;
  localparam int unsigned FILL_W = LOG2_DEPTH + 1;
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);

  logic                  rdy_prev_q;
  logic [SUM_W-1:0]      sum_q, sum_d;
  logic [LOG2_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [FILL_W-1:0]     fill_q, fill_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic                  rdy_q, rdy_d;
  logic                  valid_q, valid_d;
  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic                  accept_c;
  logic [DATA_W-1:0]     old_c;

  // Running sum update: the evicted sample only counts once the window is full.
  always_comb begin
    accept_c = data_rdy_i & ~rdy_prev_q & ~clear_i;
    old_c    = (fill_q == FILL_FULL) ? mem_q[wr_ptr_q] : '0;
    sum_d    = sum_q;
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    data_d   = data_q;
    rdy_d    = 1'b0;
    valid_d  = valid_q;
    if (clear_i) begin
      sum_d    = '0;
      wr_ptr_d = '0;
      fill_d   = '0;
      valid_d  = 1'b0;
    end else if (accept_c) begin
      sum_d    = sum_q + SUM_W'(data_i) - SUM_W'(old_c);
      wr_ptr_d = wr_ptr_q + LOG2_DEPTH'(1);
      fill_d   = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
      data_d   = sum_d[SUM_W-1:LOG2_DEPTH];
      rdy_d    = 1'b1;
      valid_d  = (fill_d == FILL_FULL);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rdy_prev_q <= 1'b0;
      sum_q      <= '0;
      wr_ptr_q   <= '0;
      fill_q     <= '0;
      data_q     <= '0;
      rdy_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      // Strobe history is tracked even during clear so a held strobe cannot retrigger.
      rdy_prev_q <= data_rdy_i;
      sum_q      <= sum_d;
      wr_ptr_q   <= wr_ptr_d;
      fill_q     <= fill_d;
      data_q     <= data_d;
      rdy_q      <= rdy_d;
      valid_q    <= valid_d;
    end
  end

  // Sample storage is not reset; the fill count masks stale entries.
  always_ff @(posedge clk_i) begin
    if (!reset_i && accept_c) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign data_o     = data_q;
  assign data_rdy_o = rdy_q;
  assign valid_o    = valid_q;

endmodule
